// File: rtl/mult_div_seq.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) sequencer owning HI/LO.
// One step per cycle; start pulses are accepted only in IDLE and a done pulse ends each operation.
module mult_div_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult,
  input  logic        div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        divzero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MULT = 3'd1,
    S_DIV  = 3'd2,
    S_DFIX = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [32:0] acc_r, acc_s;      // Booth A, or division partial remainder R
  logic [31:0] q_r, q_s;          // Booth multiplier / division quotient
  logic        qm1_r, qm1_s;
  logic [32:0] opnd_r, opnd_s;    // sign-extended multiplicand or zero-extended |divisor|
  logic [5:0]  cnt_r, cnt_s;
  logic        neg_q_r, neg_q_s;
  logic        neg_r_r, neg_r_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        divzero_r, divzero_s;
  logic [31:0] hi_r, hi_s;
  logic [31:0] lo_r, lo_s;

  logic [32:0] booth_sum_s;
  logic [32:0] div_shift_s;
  logic [32:0] div_trial_s;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    neg32 = (~v) + 32'd1;
  endfunction

  // |-2^31| stays 0x80000000, which is the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    abs32 = v[31] ? neg32(v) : v;
  endfunction

  // Next-state and datapath step logic.
  always_comb begin
    state_s   = state_r;
    acc_s     = acc_r;
    q_s       = q_r;
    qm1_s     = qm1_r;
    opnd_s    = opnd_r;
    cnt_s     = cnt_r;
    neg_q_s   = neg_q_r;
    neg_r_s   = neg_r_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    divzero_s = divzero_r;
    hi_s      = hi_r;
    lo_s      = lo_r;

    case ({q_r[0], qm1_r})
      2'b10:   booth_sum_s = acc_r - opnd_r;
      2'b01:   booth_sum_s = acc_r + opnd_r;
      default: booth_sum_s = acc_r;
    endcase
    div_shift_s = {acc_r[31:0], q_r[31]};
    div_trial_s = div_shift_s - opnd_r;

    case (state_r)
      S_IDLE: begin
        if (mult) begin
          acc_s     = 33'd0;
          q_s       = b;
          qm1_s     = 1'b0;
          opnd_s    = {a[31], a};
          cnt_s     = 6'd0;
          busy_s    = 1'b1;
          divzero_s = 1'b0;
          state_s   = S_MULT;
        end else if (div) begin
          if (b == 32'd0) begin
            divzero_s = 1'b1;
            done_s    = 1'b1;
            busy_s    = 1'b1;
            state_s   = S_DONE;
          end else begin
            acc_s     = 33'd0;
            q_s       = abs32(a);
            opnd_s    = {1'b0, abs32(b)};
            neg_q_s   = a[31] ^ b[31];
            neg_r_s   = a[31];
            cnt_s     = 6'd0;
            busy_s    = 1'b1;
            divzero_s = 1'b0;
            state_s   = S_DIV;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_MULT: begin
        acc_s = {booth_sum_s[32], booth_sum_s[32:1]};
        q_s   = {booth_sum_s[0], q_r[31:1]};
        qm1_s = q_r[0];
        cnt_s = cnt_r + 6'd1;
        if (cnt_r == 6'd31) begin
          hi_s    = acc_s[31:0];
          lo_s    = q_s;
          done_s  = 1'b1;
          state_s = S_DONE;
        end else begin
          state_s = S_MULT;
        end
      end
      S_DIV: begin
        // Remainder before the shift is below the divisor, so bit 32 of the trial is its sign.
        if (!div_trial_s[32]) begin
          acc_s = div_trial_s;
          q_s   = {q_r[30:0], 1'b1};
        end else begin
          acc_s = div_shift_s;
          q_s   = {q_r[30:0], 1'b0};
        end
        cnt_s = cnt_r + 6'd1;
        if (cnt_r == 6'd31) begin
          state_s = S_DFIX;
        end else begin
          state_s = S_DIV;
        end
      end
      S_DFIX: begin
        lo_s    = neg_q_r ? neg32(q_r) : q_r;
        hi_s    = neg_r_r ? neg32(acc_r[31:0]) : acc_r[31:0];
        done_s  = 1'b1;
        state_s = S_DONE;
      end
      S_DONE: begin
        busy_s  = 1'b0;
        state_s = S_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_IDLE;
      acc_r     <= 33'd0;
      q_r       <= 32'd0;
      qm1_r     <= 1'b0;
      opnd_r    <= 33'd0;
      cnt_r     <= 6'd0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      divzero_r <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
    end else begin
      state_r   <= state_s;
      acc_r     <= acc_s;
      q_r       <= q_s;
      qm1_r     <= qm1_s;
      opnd_r    <= opnd_s;
      cnt_r     <= cnt_s;
      neg_q_r   <= neg_q_s;
      neg_r_r   <= neg_r_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      divzero_r <= divzero_s;
      hi_r      <= hi_s;
      lo_r      <= lo_s;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign divzero = divzero_r;
  assign hi      = hi_r;
  assign lo      = lo_r;

endmodule

// File: tb/tb_mult_div_seq.sv
// Scoreboard bench for mult_div_seq: stimulus pushes expected HI/LO/divzero/latency,
// a negedge monitor pops and compares on every done pulse.
module tb_mult_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        mult;
  logic        div;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        divzero;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          start;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  mult_div_seq dut (
    .clk     (clk),
    .reset   (reset),
    .mult    (mult),
    .div     (div),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .divzero (divzero),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.name, "_hi"}, hi, e.hi);
        chk({e.name, "_lo"}, lo, e.lo);
        chk({e.name, "_divzero"}, {31'd0, divzero}, {31'd0, e.dz});
        chk({e.name, "_latency"}, cyc - e.start, e.lat);
      end
    end
  end

  task automatic start_op(input logic m, input logic d, input logic [31:0] va, input logic [31:0] vb,
                          input logic push, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz, input int elat, input string name);
    exp_t e;
    @(negedge clk);
    mult = m;
    div  = d;
    a    = va;
    b    = vb;
    if (push) begin
      e.hi = ehi; e.lo = elo; e.dz = edz; e.lat = elat; e.start = cyc; e.name = name;
      sb_q.push_back(e);
    end
    @(negedge clk);
    mult = 1'b0;
    div  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy stuck for %0d cycles expected idle", name, n);
    end
  endtask

  initial begin
    reset = 1'b1; mult = 1'b0; div = 1'b0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_divzero", {31'd0, divzero}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;

    start_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, "mul_7xm3");
    chk("mul_busy_inflight", {31'd0, busy}, 32'd1);
    wait_idle("mul_7xm3");

    start_op(1'b1, 1'b0, 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h0, 1'b0, 33, "mul_min2");
    wait_idle("mul_min2");
    start_op(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h1, 1'b0, 33, "mul_m1sq");
    wait_idle("mul_m1sq");

    start_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, "div_m7d2");
    wait_idle("div_m7d2");
    start_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h80000000, 1'b0, 34, "div_wrap");
    wait_idle("div_wrap");

    // 0x451 / 0x20 = 0x22 rem 0x11 sets up the prior HI/LO.
    start_op(1'b0, 1'b1, 32'h451, 32'h20, 1'b1, 32'h11, 32'h22, 1'b0, 34, "div_setup");
    wait_idle("div_setup");
    start_op(1'b0, 1'b1, 32'd5, 32'd0, 1'b1, 32'h11, 32'h22, 1'b1, 1, "div_zero");
    wait_idle("div_zero");
    repeat (2) @(negedge clk);
    chk("divzero_held", {31'd0, divzero}, 32'd1);
    start_op(1'b1, 1'b0, 32'd3, 32'd5, 1'b1, 32'h0, 32'd15, 1'b0, 33, "mul_after_dz");
    chk("divzero_cleared", {31'd0, divzero}, 32'd0);
    wait_idle("mul_after_dz");

    // Simultaneous starts: multiply wins; a later divide-by-zero pulse must be ignored.
    start_op(1'b1, 1'b1, 32'd6, 32'd4, 1'b1, 32'h0, 32'd24, 1'b0, 33, "mul_arb");
    repeat (8) @(negedge clk);
    div = 1'b1; a = 32'd1; b = 32'd0;
    @(negedge clk);
    div = 1'b0;
    wait_idle("mul_arb");
    repeat (5) @(negedge clk);
    chk("arb_divzero", {31'd0, divzero}, 32'd0);

    // Reset during a multiply aborts it with no done.
    start_op(1'b1, 1'b0, 32'h12345, 32'h777, 1'b0, 32'h0, 32'h0, 1'b0, 0, "mul_abort");
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    repeat (40) @(negedge clk);
    chk("abort_idle_busy", {31'd0, busy}, 32'd0);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
